// File: rtl/adder_sched_pkg.sv
// Shared types and default sizing for the round-robin adder scheduler.
package adder_sched_pkg;

    // Scheduler FSM: wait for a request, add, then hold the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_IDW  = 2;
    localparam int DEF_CNTW = 16;

endpackage : adder_sched_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer, searching upward and wrapping at NREQ-1.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any_req
);

    localparam int SW = IDW + 1;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_off;
    logic [SW-1:0]     w_sum;

    // Rotating a doubled copy puts the pointer position at bit 0, so the
    // search below is a plain lowest-set-bit scan.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NREQ'(w_dbl >> i_ptr);

    // Lowest set bit of the rotated vector is the offset from the pointer.
    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    // Undo the rotation; NREQ need not be a power of two, so wrap explicitly.
    assign w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx     = (w_sum >= SW'(NREQ)) ? IDW'(w_sum - SW'(NREQ)) : IDW'(w_sum);
    assign o_any_req = |i_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign o_grant[gi] = o_any_req && (o_idx == IDW'(gi));
        end
    endgenerate

endmodule : rr_arbiter

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered W-bit adder between NREQ
// requesters. Request: valid/ready per requester; response: valid/ready.
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = DEF_IDW,
    parameter int CNTW = DEF_CNTW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    sched_state_t   r_state;
    logic [IDW-1:0] r_ptr;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [IDW-1:0] r_gid;
    logic [W-1:0]   r_sum;
    logic           r_carry;
    logic [IDW-1:0] r_id;
    logic           r_valid;
    logic           r_busy;
    logic [CNTW-1:0] r_count;

    logic [W-1:0]    w_a [NREQ];
    logic [W-1:0]    w_b [NREQ];
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic [IDW-1:0]  w_ptr_next;
    logic [W:0]      w_add;

    // Unpack the flat operand buses into per-requester lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_a[gi] = req_a[gi*W +: W];
            assign w_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_any_req (w_any)
    );

    // Next pointer sits just past the winner so it drops to lowest priority.
    assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

    // Add at W+1 bits so the top bit is the carry-out.
    assign w_add = {1'b0, r_a} + {1'b0, r_b};

    // Grant is only offered while idle; operands are captured on that edge.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    // Scheduler FSM with registered response, busy flag and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_gid   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a[w_idx];
                        r_b     <= w_b[w_idx];
                        r_gid   <= w_idx;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    {r_carry, r_sum} <= w_add;
                    r_id    <= r_gid;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_count <= r_count + CNTW'(1);
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_carry = r_carry;
    assign rsp_id    = r_id;
    assign busy      = r_busy;
    assign op_count  = r_count;

endmodule : adder_rr_sched
